// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port (video / CPU) arbiter for an asynchronous 8-bit SRAM.
// Each access is SETUP(1) + ACTIVE(ACCESS_CYCLES) + HOLD(1). The HOLD cycle
// is also an arbitration point, so back-to-back accesses have no idle gap.
// Optional feature: define SRAM_ARB_ROUND_ROBIN_EN to alternate the grant on
// simultaneous requests; without it video always wins a tie.
//
// state  | meaning
// IDLE   | no access in flight, arbitrating every cycle
// SETUP  | address (and write data) presented, strobe inactive
// ACTIVE | strobe window, ACCESS_CYCLES long; read data captured on last cycle
// HOLD   | strobe released, winner acked, next arbitration point
module sram_arbiter #(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        vid_req,
    input  logic [20:0] vid_addr,
    output logic        vid_ack,
    output logic [7:0]  vid_data,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [20:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    output logic [20:0] SRAM_A,
    inout  wire  [7:0]  SRAM_D,
    output logic        SRAM_WE_n
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    logic [1:0] state;
    logic [3:0] cnt;
    logic       grant_vid;
    logic       write_q;
    logic [7:0] wdata_q;
    logic       arb_point;
    logic       pick_vid;

    assign arb_point = (state == ST_IDLE) || (state == ST_HOLD);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic last_vid;

    // On a tie the port that did not win last time gets the bus
    always_comb begin
        pick_vid = vid_req && (!cpu_req || !last_vid);
    end

    // Remember who won the most recent grant
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            last_vid <= 1'b0;
        end else if (arb_point && (vid_req || cpu_req)) begin
            last_vid <= pick_vid;
        end
    end
`else
    // Fixed priority: video wins any tie
    always_comb begin
        pick_vid = vid_req;
    end
`endif

    // Access sequencer: grant, strobe timing and read-data capture
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            grant_vid <= 1'b0;
            write_q   <= 1'b0;
            wdata_q   <= 8'd0;
            SRAM_A    <= 21'd0;
            vid_data  <= 8'd0;
            cpu_rdata <= 8'd0;
        end else begin
            case (state)
                ST_IDLE, ST_HOLD: begin
                    if (vid_req || cpu_req) begin
                        state     <= ST_SETUP;
                        grant_vid <= pick_vid;
                        SRAM_A    <= pick_vid ? vid_addr : cpu_addr;
                        write_q   <= !pick_vid && cpu_we;
                        wdata_q   <= cpu_wdata;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    cnt   <= CNT_LOAD;
                    state <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (cnt == 4'd0) begin
                        state <= ST_HOLD;
                        if (!write_q) begin
                            if (grant_vid) begin
                                vid_data <= SRAM_D;
                            end else begin
                                cpu_rdata <= SRAM_D;
                            end
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Bus outputs decoded from the registered access state
    assign SRAM_WE_n = !((state == ST_ACTIVE) && write_q);
    assign SRAM_D    = (write_q && (state != ST_IDLE)) ? wdata_q : 8'bz;
    assign vid_ack   = (state == ST_HOLD) && grant_vid;
    assign cpu_ack   = (state == ST_HOLD) && !grant_vid;

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ACCESS_CYCLES, default 2, number of SRAM strobe cycles per access, legal range 1..15.
REQ-002 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 vid_req  in  1  video fetch request, level, held until vid_ack.
REQ-005 vid_addr  in  21  video byte address.
REQ-006 vid_ack  out  1  one-cycle pulse; vid_data valid in the same cycle.
REQ-007 vid_data  out  8  registered video read data.
REQ-008 cpu_req  in  1  CPU request, level, held until cpu_ack.
REQ-009 cpu_we  in  1  1 = write, 0 = read; sampled at grant.
REQ-010 cpu_addr  in  21  CPU byte address.
REQ-011 cpu_wdata  in  8  CPU write data.
REQ-012 cpu_ack  out  1  one-cycle pulse; cpu_rdata valid in the same cycle for reads.
REQ-013 cpu_rdata  out  8  registered CPU read data.
REQ-014 SRAM_A  out  21  external SRAM address.
REQ-015 SRAM_D  inout  8  external SRAM data; driven only during CPU writes, Z otherwise.
REQ-016 SRAM_WE_n  out  1  external SRAM write strobe, active low.

Function
REQ-017 FSM states are IDLE, SETUP, ACTIVE and HOLD; every access is SETUP(1) + ACTIVE(ACCESS_CYCLES) + HOLD(1).
REQ-018 IDLE: if any req is high, latch the winner, its address, cpu_we and cpu_wdata, then go to SETUP; otherwise stay in IDLE.
REQ-019 SETUP: SRAM_A = latched address; SRAM_WE_n = 1; SRAM_D is driven with latched data if the access is a write.
REQ-020 ACTIVE: a 4-bit counter counts ACCESS_CYCLES cycles; SRAM_WE_n = 0 for every ACTIVE cycle of a write; SRAM_A and SRAM_D are stable.
REQ-021 For a read, SRAM_D is sampled on the last ACTIVE cycle into the winner's data register.
REQ-022 HOLD: SRAM_WE_n = 1; address and write data are still driven; the winner's ack pulses for exactly this cycle.
REQ-023 HOLD arbitrates like IDLE, sampling req in the HOLD cycle: a pending req goes directly to SETUP (back-to-back); otherwise the FSM goes to IDLE.
REQ-024 A requester that keeps req high in its own ack cycle is granted a new access; requesters drop req in the ack cycle to avoid this.
REQ-025 Latency from req-high-in-IDLE to ack is ACCESS_CYCLES+2 cycles; steady-state throughput is one access every ACCESS_CYCLES+2 cycles.
REQ-026 Video accesses are read-only and never drive SRAM_D.
REQ-027 Addresses pass through unmodified; 0x1FFFFF is a legal address and does not wrap.
REQ-028 vid_data and cpu_rdata hold their value until the next read completes for the same port.
REQ-029 A req change during an access owned by the other port has no effect until the next arbitration point.

Reset
REQ-030 Reset, including reset mid-access, forces the following on the next edge: IDLE; SRAM_WE_n = 1; SRAM_D = Z; SRAM_A = 0; both acks = 0; vid_data = cpu_rdata = 0; counter = 0; last-grant = CPU.
REQ-031 An access aborted by reset produces no ack.

Configuration
REQ-032 Macro SRAM_ARB_ROUND_ROBIN_EN defined: on a simultaneous request, the grant goes to the port not granted last; last-grant is updated at each grant.
REQ-033 Macro not defined: video always wins on a simultaneous request, and the last-grant register is not built.

Verification
REQ-034 All scenarios use ACCESS_CYCLES = 2, so each access takes 4 cycles.
- CPU write 0x1ABCD/0x5A from IDLE -> SRAM_WE_n low exactly cycles 2-3; SRAM_D = 0x5A in cycles 1-4; cpu_ack pulses in cycle 4.
- CPU read 0x1ABCD with the SRAM model returning 0x5A -> cpu_ack in cycle 4 with cpu_rdata = 0x5A; SRAM_D never driven by the DUT.
- vid_req and cpu_req rise together and are held for 3 acks -> macro off: grant order vid,vid,vid; macro on: vid,cpu,vid.
- vid_req held continuously, vid_addr incremented on each ack from 0x00000 -> vid_ack every 4 cycles; SRAM_A = 0, 1, 2, ...; no IDLE cycles.
- reset asserted in the first ACTIVE cycle of a write -> next cycle SRAM_WE_n = 1, SRAM_D = Z, no cpu_ack; a fresh CPU read afterwards completes normally.
- vid read at 0x1FFFFF -> SRAM_A = 0x1FFFFF for all 4 cycles; vid_data equals the model byte.
